// File: rtl/uart_tx_arbiter.sv
// Arbitrates the UART transmitter between a 2*DW ALU result and a DW register-file read, sending bytes LSB first.
// Optional feature: define UART_ARB_RR_EN for round-robin arbitration (default: fixed priority ALU > RF).
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned START_TO   = 4,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      alu_valid,
  input  logic [2*DATA_WIDTH-1:0]   alu_data,
  output logic                      alu_ready,
  input  logic                      rf_valid,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  output logic                      rf_ready,
  input  logic                      tx_busy,
  output logic                      tx_valid,
  output logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      grant_src,
  output logic                      active,
  output logic                      tx_err
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned WW = 2 * DATA_WIDTH;
  localparam int unsigned TW = $clog2(START_TO + 1);
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

  state_t         state_q, state_d;
  logic [WW-1:0]  shreg_q;
  logic [1:0]     byte_cnt_q;
  logic [1:0]     nbytes_q;
  logic [RW-1:0]  retry_q;
  logic [TW-1:0]  tmo_q;
  logic           alu_pick;
  logic           accept;
  logic           retry;
  logic           abandon;
  logic           byte_done;
  logic           last_byte;

`ifdef UART_ARB_RR_EN
  // rr_ptr_q = 1 favours ALU on a tie; flips to the loser after every accept.
  logic rr_ptr_q;
  assign alu_pick = alu_valid && (!rf_valid || rr_ptr_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q <= 1'b1;
    end else if (accept) begin
      rr_ptr_q <= !alu_pick;
    end
  end
`else
  assign alu_pick = alu_valid;
`endif

  assign tx_data = shreg_q[DW-1:0];

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, accept strobes and datapath controls.
  always_comb begin
    state_d   = state_q;
    alu_ready = 1'b0;
    rf_ready  = 1'b0;
    accept    = 1'b0;
    retry     = 1'b0;
    abandon   = 1'b0;
    byte_done = 1'b0;
    last_byte = ((byte_cnt_q + 2'd1) == nbytes_q);
    case (state_q)
      IDLE: begin
        if (!RST && !tx_busy && (alu_valid || rf_valid)) begin
          accept    = 1'b1;
          alu_ready = alu_pick;
          rf_ready  = !alu_pick;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_START;
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(START_TO - 2)) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry   = 1'b1;
            state_d = ISSUE;
          end else begin
            abandon   = 1'b1;
            byte_done = 1'b1;
            state_d   = last_byte ? IDLE : ISSUE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
          state_d   = last_byte ? IDLE : ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      nbytes_q   <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      tx_valid   <= 1'b0;
      active     <= 1'b0;
      grant_src  <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      tx_valid <= (state_d == ISSUE);
      active   <= (state_d != IDLE);
      if (accept) begin
        shreg_q    <= alu_pick ? alu_data : WW'(rf_data);
        nbytes_q   <= alu_pick ? 2'd2 : 2'd1;
        byte_cnt_q <= '0;
        retry_q    <= '0;
        grant_src  <= alu_pick;
      end
      // Pulses land START_TO cycles apart when the transmitter never answers.
      if (state_q == ISSUE) begin
        tmo_q <= '0;
      end else if (state_q == WAIT_START) begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (retry) begin
        retry_q <= retry_q + RW'(1);
      end
      if (abandon) begin
        tx_err <= 1'b1;
      end
      if (byte_done) begin
        shreg_q    <= shreg_q >> DW;
        byte_cnt_q <= byte_cnt_q + 2'd1;
        retry_q    <= '0;
      end
    end
  end

endmodule
